// File: rtl/keypad_responder_pkg.sv
// Shared constants, state encoding and row decode for the keypad responder
// and any scanner-side monitors.
package keypad_responder_pkg;

  localparam logic [3:0] ROW_IDLE = 4'b1111;
  localparam logic [3:0] COL_IDLE = 4'b1111;
  localparam logic [3:0] ROW0     = 4'b1110;
  localparam logic [3:0] ROW1     = 4'b1101;
  localparam logic [3:0] ROW2     = 4'b1011;
  localparam logic [3:0] ROW3     = 4'b0111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Returns {valid, row index}; anything but a single low strobe is invalid.
  function automatic logic [2:0] row_decode(input logic [3:0] row);
    logic [2:0] res;
    case (row)
      ROW0:    res = 3'b100;
      ROW1:    res = 3'b101;
      ROW2:    res = 3'b110;
      ROW3:    res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_frame_tick.sv
// Frame-end detector: one tick when the scanner leaves the last row (0111).
module keypad_frame_tick
  import keypad_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic       tick
);

  logic [3:0] prev_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_row <= ROW_IDLE;
    else     prev_row <= row;
  end

  assign tick = (prev_row == ROW3) && (row != ROW3);

endmodule

// File: rtl/keypad_responder.sv
// Keypad responder: closes one matrix contact for a number of scan frames,
// then enforces a released gap before taking the next command.
module keypad_responder
  import keypad_responder_pkg::*;
#(
  parameter int HOLD_SCANS    = 4,
  parameter int RELEASE_SCANS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [3:0] cmd_hold,
  input  logic       cmd_abort,
  input  logic [3:0] keypadRow,
  output logic [3:0] keypadCol,
  output logic       pressed,
  output logic       done,
  output logic       proto_err
);

  localparam logic [3:0] HOLD_DEF = 4'(HOLD_SCANS);
  localparam logic [3:0] REL_LEN  = 4'(RELEASE_SCANS);

  state_t     state_q, state_d;
  logic [3:0] key_q, key_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pressed_d, ready_d, done_d;
  logic [3:0] col_d;
  logic [2:0] row_info;
  logic       row_ok;
  logic       tick;

  keypad_frame_tick u_tick (
    .clk  (clk),
    .rst  (rst),
    .row  (keypadRow),
    .tick (tick)
  );

  assign row_info = row_decode(keypadRow);
  assign row_ok   = row_info[2];

  // Column drive uses next-cycle press state so keypadCol and pressed move together.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    pressed_d = pressed;
    ready_d   = cmd_ready;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          key_d     = cmd_key;
          hold_d    = (cmd_hold == 4'd0) ? HOLD_DEF : cmd_hold;
          cnt_d     = 4'd0;
          state_d   = PRESS;
          pressed_d = 1'b1;
          ready_d   = 1'b0;
        end
      end
      PRESS: begin
        if (cmd_abort) begin
          state_d   = RELEASE;
          cnt_d     = 4'd0;
          pressed_d = 1'b0;
        end else if (tick && (cnt_q != hold_q)) begin
          if (cnt_q + 4'd1 == hold_q) begin
            state_d   = RELEASE;
            cnt_d     = 4'd0;
            pressed_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      RELEASE: begin
        if (tick && (cnt_q != REL_LEN)) begin
          if (cnt_q + 4'd1 == REL_LEN) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = 4'd0;
        pressed_d = 1'b0;
        ready_d   = 1'b1;
      end
    endcase

    col_d = COL_IDLE;
    if (pressed_d && row_ok && (row_info[1:0] == key_d[3:2]))
      col_d[key_d[1:0]] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= 4'd0;
      hold_q    <= 4'd0;
      cnt_q     <= 4'd0;
      keypadCol <= COL_IDLE;
      pressed   <= 1'b0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      keypadCol <= col_d;
      pressed   <= pressed_d;
      cmd_ready <= ready_d;
      done      <= done_d;
      proto_err <= proto_err | (pressed & ~row_ok);
    end
  end

endmodule
